mc_controller: RTL

Multi-cycle sequencer for the MIPS datapath (pc, im, gpr, alu, dm, npc, ext), replacing the single-cycle controller.
- Steps each instruction through FETCH/DECODE/EXE/MEM/WB.
- Drives per-state write enables and datapath mux selects.
- Supports a configurable fetch wait and a data-memory ready handshake.

---
 rtl/mc_pkg.sv | 15 +
 rtl/mc_if.sv | 16 +
 rtl/mc_decode.sv | 25 ++
 rtl/mc_controller.sv | 97 +++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: state, opcode/funct and datapath select encodings for the multi-cycle MIPS controller
package mc_pkg;
  typedef enum logic [2:0] {S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_SLT = 6'b101010, FN_JR = 6'b001000;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2, RD_R30 = 2'd3;
  localparam logic [1:0] M2R_ALU = 2'd0, M2R_MEM = 2'd1, M2R_PC4 = 2'd2, M2R_ONE = 2'd3;
  localparam logic [1:0] NPC_SEQ = 2'd0, NPC_BEQ = 2'd1, NPC_JMP = 2'd2, NPC_JR = 2'd3;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_SLT = 3'd3;
  localparam int C_ADDU = 0, C_SUBU = 1, C_SLT = 2, C_JR = 3, C_ORI = 4, C_LUI = 5;
  localparam int C_ADDI = 6, C_LW = 7, C_SW = 8, C_BEQ = 9, C_J = 10, C_JAL = 11, C_NUM = 12;
  typedef logic [C_NUM-1:0] cls_t;
endpackage

// File: rtl/mc_if.sv
// mc_if: controller <-> datapath signals; master is the controller side
interface mc_if;
  logic [5:0] opcode, funct;
  logic zero, overflow, mem_rdy;
  logic PCWr, IRWr, ALUSrc, MemWr, MemRd, RegWr, illegal;
  logic [1:0] RegDst, MemToReg, nPC_sel, ExtOp;
  logic [2:0] ALUCtr, state;
  modport master (
    input opcode, funct, zero, overflow, mem_rdy,
    output PCWr, IRWr, RegDst, ALUSrc, MemToReg, MemWr, MemRd, RegWr, nPC_sel, ExtOp, ALUCtr, illegal, state
  );
  modport slave (
    output opcode, funct, zero, overflow, mem_rdy,
    input PCWr, IRWr, RegDst, ALUSrc, MemToReg, MemWr, MemRd, RegWr, nPC_sel, ExtOp, ALUCtr, illegal, state
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: opcode/funct to one-hot instruction class plus valid
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       valid
);
  logic r;
  assign r = opcode == OP_RTYPE;
  assign cls[C_ADDU] = r && funct == FN_ADDU;
  assign cls[C_SUBU] = r && funct == FN_SUBU;
  assign cls[C_SLT]  = r && funct == FN_SLT;
  assign cls[C_JR]   = r && funct == FN_JR;
  assign cls[C_ORI]  = opcode == OP_ORI;
  assign cls[C_LUI]  = opcode == OP_LUI;
  assign cls[C_ADDI] = opcode == OP_ADDI;
  assign cls[C_LW]   = opcode == OP_LW;
  assign cls[C_SW]   = opcode == OP_SW;
  assign cls[C_BEQ]  = opcode == OP_BEQ;
  assign cls[C_J]    = opcode == OP_J;
  assign cls[C_JAL]  = opcode == OP_JAL;
  assign valid = |cls;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS sequencer FETCH/DECODE/EXE/MEM/WB; MC_OVF_TRAP_EN enables the addi overflow trap
module mc_controller
  import mc_pkg::*;
#(
  parameter int FETCH_WAIT = 0
) (
  input logic  clk,
  input logic  rst,
  mc_if.master bus
);
  state_t state_q, state_d;
  logic [3:0] wait_q, wait_d;
  cls_t cls;
  logic valid, ovf_trap, is_r, is_mem, alusrc;
  logic [1:0] ext;
  logic [2:0] aluctr;
  mc_decode u_dec (.opcode(bus.opcode), .funct(bus.funct), .cls(cls), .valid(valid));
`ifdef MC_OVF_TRAP_EN
  assign ovf_trap = cls[C_ADDI] && bus.overflow;
`else
  logic unused_ovf;
  assign unused_ovf = bus.overflow;
  assign ovf_trap = 1'b0;
`endif
  assign is_r   = cls[C_ADDU] | cls[C_SUBU] | cls[C_SLT];
  assign is_mem = cls[C_LW] | cls[C_SW];
  assign ext    = cls[C_LUI] ? EXT_LUI : (cls[C_ADDI] | is_mem) ? EXT_SIGN : EXT_ZERO;
  assign alusrc = cls[C_ORI] | cls[C_LUI] | cls[C_ADDI] | is_mem;
  assign aluctr = (cls[C_SUBU] | cls[C_BEQ]) ? ALU_SUB : cls[C_SLT] ? ALU_SLT :
                  (cls[C_ORI] | cls[C_LUI]) ? ALU_OR : ALU_ADD;
  assign bus.state = state_q;
  // Outputs are gated by rst so enables fall the moment reset asserts, even mid-MEM
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    bus.PCWr = 1'b0;
    bus.IRWr = 1'b0;
    bus.RegDst = RD_RT;
    bus.ALUSrc = 1'b0;
    bus.MemToReg = M2R_ALU;
    bus.MemWr = 1'b0;
    bus.MemRd = 1'b0;
    bus.RegWr = 1'b0;
    bus.nPC_sel = NPC_SEQ;
    bus.ExtOp = EXT_ZERO;
    bus.ALUCtr = ALU_ADD;
    bus.illegal = 1'b0;
    if (rst) begin
      if (state_q inside {S_EXE, S_MEM, S_WB}) begin
        bus.ExtOp = ext;
        bus.ALUSrc = alusrc;
        bus.ALUCtr = aluctr;
      end
      case (state_q)
        S_FETCH: begin
          bus.IRWr = wait_q == 4'(FETCH_WAIT);
          bus.PCWr = wait_q == 4'(FETCH_WAIT);
          wait_d = wait_q == 4'(FETCH_WAIT) ? 4'd0 : wait_q + 4'd1;
          state_d = wait_q == 4'(FETCH_WAIT) ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          bus.illegal = !valid;
          state_d = valid ? S_EXE : S_FETCH;
        end
        S_EXE: begin
          bus.nPC_sel = cls[C_BEQ] ? NPC_BEQ : cls[C_JR] ? NPC_JR : (cls[C_J] | cls[C_JAL]) ? NPC_JMP : NPC_SEQ;
          bus.PCWr = cls[C_BEQ] ? bus.zero : cls[C_J] | cls[C_JAL] | cls[C_JR];
          bus.RegWr = cls[C_JAL];
          bus.RegDst = cls[C_JAL] ? RD_RA : RD_RT;
          bus.MemToReg = cls[C_JAL] ? M2R_PC4 : M2R_ALU;
          state_d = is_mem ? S_MEM : (is_r | cls[C_ORI] | cls[C_LUI] | cls[C_ADDI]) ? S_WB : S_FETCH;
        end
        S_MEM: begin
          bus.MemRd = cls[C_LW];
          bus.MemWr = cls[C_SW];
          state_d = !bus.mem_rdy ? S_MEM : cls[C_LW] ? S_WB : S_FETCH;
        end
        S_WB: begin
          bus.RegWr = 1'b1;
          bus.RegDst = ovf_trap ? RD_R30 : is_r ? RD_RD : RD_RT;
          bus.MemToReg = ovf_trap ? M2R_ONE : cls[C_LW] ? M2R_MEM : M2R_ALU;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
    end
  end
endmodule
